// File: rtl/sha256_msg_schedule.sv
// ============================================================================
//  Module   : sha256_msg_schedule
//  Purpose  : Expands each padded 512-bit SHA-256 message block into the 64
//             schedule words W0..W63 and emits one 32-bit word per handshake.
//             A 16-word sliding window holds all the state needed.
//  Options  : `define SHA256_MSG_SCHEDULE_IDX_EN adds port data_out_idx, the
//             index t of the word currently on data_out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_msg_schedule (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic         sync_rst,
  input  logic [511:0] data_in,
  input  logic         data_in_last,
  input  logic         data_in_valid,
  output logic         data_in_ready,
  output logic [31:0]  data_out,
  output logic         data_out_last,
  output logic         data_out_valid,
  input  logic         data_out_ready
`ifdef SHA256_MSG_SCHEDULE_IDX_EN
  ,
  output logic [5:0]   data_out_idx
`endif
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  localparam logic [5:0] C_T_LAST = 6'd63;
  localparam logic [5:0] C_T_SHIFT = 6'd15;

  state_t      r_state;
  logic [5:0]  r_t;
  logic [31:0] r_win [16];
  logic [31:0] r_data;
  logic        r_valid;
  logic        r_last;
  logic        r_blk_last;

  logic [31:0] w_blk [16];
  logic [31:0] w_new;
  logic [31:0] w_next_word;
  logic [5:0]  w_t_next;
  logic        w_out_hs;
  logic        w_wrap;
  logic        w_in_hs;

  // small sigma functions of the SHA-256 schedule
  function automatic logic [31:0] f_sig0(input logic [31:0] x);
    f_sig0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] f_sig1(input logic [31:0] x);
    f_sig1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  // word 0 of the block sits in the most significant bits (big-endian)
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_blk
      assign w_blk[gi] = data_in[511 - 32*gi -: 32];
    end
  endgenerate

  // once the window holds W(t-15)..W(t), slots 0/1/9/14 feed W(t+1)
  assign w_new       = f_sig1(r_win[14]) + r_win[9] + f_sig0(r_win[1]) + r_win[0];
  assign w_t_next    = r_t + 6'd1;
  assign w_next_word = (r_t < C_T_SHIFT) ? r_win[w_t_next[3:0]] : w_new;

  assign w_out_hs = r_valid & en & data_out_ready;
  assign w_wrap   = (r_t == C_T_LAST) & w_out_hs;

  // ready in IDLE, or when W63 leaves this cycle so the next block loads bubble-free
  assign data_in_ready = en & ((r_state == S_IDLE) | w_wrap);
  assign w_in_hs       = data_in_valid & data_in_ready;

  assign data_out       = r_data;
  assign data_out_last  = r_last;
  assign data_out_valid = r_valid & en;
`ifdef SHA256_MSG_SCHEDULE_IDX_EN
  assign data_out_idx   = r_t;
`endif

  // block load, word sequencing and window shifting
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_t        <= 6'd0;
      r_data     <= 32'd0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_blk_last <= 1'b0;
      for (int i = 0; i < 16; i++) r_win[i] <= 32'd0;
    end else if (sync_rst) begin
      r_state    <= S_IDLE;
      r_t        <= 6'd0;
      r_data     <= 32'd0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_blk_last <= 1'b0;
      for (int i = 0; i < 16; i++) r_win[i] <= 32'd0;
    end else if (en) begin
      if (w_in_hs) begin
        r_state    <= S_EMIT;
        r_t        <= 6'd0;
        r_data     <= w_blk[0];
        r_valid    <= 1'b1;
        r_last     <= 1'b0;
        r_blk_last <= data_in_last;
        for (int i = 0; i < 16; i++) r_win[i] <= w_blk[i];
      end else if (w_out_hs) begin
        if (r_t == C_T_LAST) begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end else begin
          r_t    <= w_t_next;
          r_data <= w_next_word;
          r_last <= r_blk_last & (w_t_next == C_T_LAST);
          if (r_t >= C_T_SHIFT) begin
            for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
            r_win[15] <= w_new;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sha256_msg_schedule.sv
// ============================================================================
//  Module   : tb_sha256_msg_schedule
//  Purpose  : Scoreboard bench for sha256_msg_schedule. A reference model
//             expands each accepted block into 64 words; a monitor pops and
//             compares every word the DUT hands over.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         en = 1'b1;
  logic         sync_rst = 1'b0;
  logic [511:0] data_in = '0;
  logic         data_in_last = 1'b0;
  logic         data_in_valid = 1'b0;
  logic         data_in_ready;
  logic [31:0]  data_out;
  logic         data_out_last;
  logic         data_out_valid;
  logic         data_out_ready = 1'b1;
`ifdef SHA256_MSG_SCHEDULE_IDX_EN
  logic [5:0]   data_out_idx;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          rdy_rand = 1'b0;

  logic [31:0] exp_w[$];
  logic        exp_last[$];
  int          exp_idx[$];
  logic [31:0] got_log[$];
  int          hs_log[$];

  sha256_msg_schedule dut (
    .clk            (clk),
    .nrst           (nrst),
    .en             (en),
    .sync_rst       (sync_rst),
    .data_in        (data_in),
    .data_in_last   (data_in_last),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_last  (data_out_last),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready)
`ifdef SHA256_MSG_SCHEDULE_IDX_EN
    ,
    .data_out_idx   (data_out_idx)
`endif
  );

  always #5 clk = ~clk;

  // cycle counter for throughput checks
  always @(posedge clk) cyc <= cyc + 1;

  // consumer readiness: always high, or randomly deasserted
  always @(posedge clk) begin
    #1;
    data_out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // reference model: full 64-word schedule from the textbook recurrence
  task automatic model_push(input logic [511:0] blk, input logic last);
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      exp_w.push_back(w[t]);
      exp_last.push_back(last && (t == 63));
      exp_idx.push_back(t);
    end
  endtask

  task automatic flush_model();
    exp_w.delete();
    exp_last.delete();
    exp_idx.delete();
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // monitor: compares every accepted word, and the held word during stalls
  always @(negedge clk) begin
    logic [31:0] ew;
    logic        el;
    int          ei;
    if (nrst && data_out_valid) begin
      if (data_out_ready) begin
        if (exp_w.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got %0h, expected no output", data_out);
        end else begin
          ew = exp_w.pop_front();
          el = exp_last.pop_front();
          ei = exp_idx.pop_front();
          check("word", {32'd0, data_out}, {32'd0, ew});
          check("last", {63'd0, data_out_last}, {63'd0, el});
`ifdef SHA256_MSG_SCHEDULE_IDX_EN
          check("idx", {58'd0, data_out_idx}, 64'(ei));
`endif
          got_log.push_back(data_out);
          hs_log.push_back(cyc);
        end
      end else if (exp_w.size() != 0) begin
        check("stall_hold", {32'd0, data_out}, {32'd0, exp_w[0]});
      end
    end
  end

  // present one block and hold it until accepted; leaves the caller at posedge+1
  task automatic send(input logic [511:0] blk, input logic last);
    data_in       = blk;
    data_in_last  = last;
    data_in_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (data_in_ready) begin
        model_push(blk, last);
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_err++;
    $display("FAIL send_timeout: got no data_in_ready, expected acceptance");
    data_in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_w.size() == 0 && !data_out_valid) return;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    n_err++;
    $display("FAIL drain_timeout: got %0d words pending, expected 0", exp_w.size());
  endtask

  task automatic wait_hs(input int n);
    for (int i = 0; i < 3000; i++) begin
      if (got_log.size() >= n) return;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    n_err++;
    $display("FAIL hs_timeout: got %0d words, expected %0d", got_log.size(), n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] abc;
    int base;
    abc = {32'h61626380, 448'd0, 32'h00000018};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {63'd0, data_out_valid}, 64'd0);
    check("rst_data",  {32'd0, data_out}, 64'd0);
    check("rst_last",  {63'd0, data_out_last}, 64'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {63'd0, data_in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // "abc" block, ready high
    base = got_log.size();
    send(abc, 1'b1);
    wait_drain();
    check("abc_count", 64'(got_log.size() - base), 64'd64);
    check("abc_W0",  {32'd0, got_log[base+0]},  64'h61626380);
    check("abc_W15", {32'd0, got_log[base+15]}, 64'h00000018);
    check("abc_W16", {32'd0, got_log[base+16]}, 64'h61626380);
    check("abc_W17", {32'd0, got_log[base+17]}, 64'h000F0000);
    check("abc_cycles", 64'(hs_log[base+63] - hs_log[base]), 64'd63);

    // all-zero non-last block
    base = got_log.size();
    send('0, 1'b0);
    wait_drain();
    check("zero_count", 64'(got_log.size() - base), 64'd64);

    // two blocks back to back
    base = got_log.size();
    send(rand_block(), 1'b0);
    send(rand_block(), 1'b1);
    wait_drain();
    check("b2b_count", 64'(got_log.size() - base), 64'd128);
    check("b2b_cycles", 64'(hs_log[base+127] - hs_log[base]), 64'd127);

    // "abc" with random consumer stalls
    rdy_rand = 1'b1;
    base = got_log.size();
    send(abc, 1'b1);
    wait_drain();
    rdy_rand = 1'b0;
    check("stall_count", 64'(got_log.size() - base), 64'd64);
    check("stall_W17", {32'd0, got_log[base+17]}, 64'h000F0000);
    @(posedge clk);
    #1;

    // en dropped for 5 cycles at t=20
    base = got_log.size();
    send(rand_block(), 1'b1);
    wait_hs(base + 20);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("en_valid", {63'd0, data_out_valid}, 64'd0);
      check("en_in_ready", {63'd0, data_in_ready}, 64'd0);
      check("en_hold", {32'd0, data_out}, {32'd0, exp_w[0]});
      @(posedge clk);
      #1;
    end
    en = 1'b1;
    wait_drain();
    check("en_count", 64'(got_log.size() - base), 64'd64);

    // sync_rst at t=30
    base = got_log.size();
    send(rand_block(), 1'b1);
    wait_hs(base + 30);
    sync_rst = 1'b1;
    @(posedge clk);
    #1;
    sync_rst = 1'b0;
    @(negedge clk);
    check("srst_valid", {63'd0, data_out_valid}, 64'd0);
    check("srst_data",  {32'd0, data_out}, 64'd0);
    check("srst_in_ready", {63'd0, data_in_ready}, 64'd1);
    flush_model();
    @(posedge clk);
    #1;

    // new block after sync_rst, then async reset mid-block
    base = got_log.size();
    send(rand_block(), 1'b0);
    wait_hs(base + 10);
    #2;
    nrst = 1'b0;
    #1;
    check("arst_valid", {63'd0, data_out_valid}, 64'd0);
    check("arst_data",  {32'd0, data_out}, 64'd0);
    check("arst_last",  {63'd0, data_out_last}, 64'd0);
    flush_model();
    @(posedge clk);
    #1;
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_no_output", {63'd0, data_out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;

    // fresh block after reset starts from W0
    base = got_log.size();
    send(abc, 1'b1);
    wait_drain();
    check("post_count", 64'(got_log.size() - base), 64'd64);
    check("post_W0", {32'd0, got_log[base]}, 64'h61626380);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
